mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Parametrised memory-stage access controller between the EX/MEM pipeline register and a variable-latency
//  data memory (cache or multi-cycle mem_system). Owns the request handshake: holds Rd/Wr until Done,
//  captures read data, generates pipeline stall, gates accesses on upstream stall/global error,
//  qualifies halt, and flags access timeouts.
// PARAMETERS
//  DW          16   data width (bits)
//  AW          16   address width (bits)
//  TIMEOUT     64   max cycles in BUSY before timeout error; 0 = timeout disabled
//  CW          7    timeout counter width, must satisfy 2**CW > TIMEOUT
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous active-high reset
//  mem_read     in   1   EX/MEM load request (level, held while stalled)
//  mem_write    in   1   EX/MEM store request (level, held while stalled)
//  addr         in   AW  access address (ALU result)
//  wdata        in   DW  store data
//  halt_in      in   1   halt instruction in MEM
//  err_in       in   1   error forwarded from EX/MEM
//  global_err   in   1   processor-wide error; blocks new accesses
//  stall_up     in   1   earlier-stage stall; blocks new accesses
//  m_rd         out  1   memory read strobe (registered)
//  m_wr         out  1   memory write strobe (registered)
//  m_addr       out  AW  latched access address
//  m_wdata      out  DW  latched store data
//  m_rdata      in   DW  memory read data, valid with m_done
//  m_done       in   1   memory access complete (1-cycle pulse)
//  m_err        in   1   memory error (sampled every cycle)
//  m_dump       out  1   createdump to memory
//  rdata        out  DW  load result, held until next load completes
//  mem_stall    out  1   stall request to pipeline
//  halt_out     out  1   qualified halt to testbench/writeback
//  err          out  1   sticky error
// BEHAVIOUR
//  Reset: state=IDLE; m_rd=m_wr=0; m_addr, m_wdata, rdata = 0; mem_stall=0; halt_out=0; m_dump=0; err=0; counter=0.
//  go = (mem_read|mem_write) & ~global_err & ~stall_up & ~err.
//  IDLE: go -> latch addr/wdata, m_rd<=mem_read, m_wr<=mem_write & ~mem_read (read wins if both), cnt<=0, ->BUSY.
//  BUSY: m_rd/m_wr held; cnt++ per cycle. m_done -> rdata<=m_rdata if read, drop strobes, ->DONE.
//    TIMEOUT!=0 & cnt==TIMEOUT-1 & ~m_done -> err<=1, drop strobes, ->IDLE.
//  DONE: one cycle, strobes low, ->IDLE; a new go is not taken here (one bubble minimum per access).
//  mem_stall = (IDLE & go) | BUSY (combinational). DONE -> 0, so load/store latency = m_done latency + 2 cycles.
//  Access held by pipeline at DONE is considered complete; the same request re-seen in IDLE next cycle is a NEW access
//    (pipeline must advance on mem_stall=0).
//  halt_out = halt_in & ~mem_stall; m_dump = halt_out. No access issued while halt_out=1.
//  err <= err | m_err | err_in | timeout; cleared only by rst. err=1 blocks go; in-flight access finishes normally.
//  rst mid-access: strobes drop next edge, rdata cleared, no m_done wait.
//  m_done in IDLE/DONE: ignored. Simultaneous m_done and timeout: m_done wins, no error.
// CONFIGURATION
//  MEM_ALIGN_CHK_EN defined: in IDLE, go with addr[0]==1 and DW>8 -> no access, err<=1, stall 0 that cycle.
//  MEM_ALIGN_CHK_EN undefined: addr passed unchanged; alignment is the memory's responsibility.
// TESTING
//  Load addr=0x0010, m_done 3 cyc after m_rd, m_rdata=0xBEEF -> mem_stall 1 for 4 cyc, rdata=0xBEEF, m_rd low after done.
//  Store addr=0x0020 wdata=0x1234, stall_up=1 for 2 cyc -> no m_wr until stall_up=0; then m_wr with m_wdata=0x1234.
//  global_err=1 with mem_write=1 -> m_wr stays 0, mem_stall 0; err=1 only if err_in/m_err also set.
//  TIMEOUT=4, m_done never -> err=1 after 4 BUSY cycles, strobes 0, subsequent loads blocked.
//  halt_in=1 while store BUSY -> halt_out=0 until DONE cycle, then halt_out=m_dump=1.
//  MEM_ALIGN_CHK_EN: load addr=0x0011 -> err=1, m_rd never asserted; rst clears err.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: holds Rd/Wr strobes until the memory answers, stalls the pipeline,
// qualifies halt and raises a sticky error. Define MEM_ALIGN_CHK_EN to reject odd addresses when DW > 8.
module mem_stage_ctrl #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          halt_in,
    input  logic          err_in,
    input  logic          global_err,
    input  logic          stall_up,
    output logic          m_rd,
    output logic          m_wr,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_done,
    input  logic          m_err,
    output logic          m_dump,
    output logic [DW-1:0] rdata,
    output logic          mem_stall,
    output logic          halt_out,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          m_rd_q, m_wr_q, err_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q, rdata_q;

    logic go, misalign, issue, align_err, timeout, err_d;

    assign go = (mem_read | mem_write) & ~global_err & ~stall_up & ~err_q;

`ifdef MEM_ALIGN_CHK_EN
    assign misalign = (DW > 8) ? addr[0] : 1'b0;
`else
    assign misalign = 1'b0;
`endif

    assign issue     = (state_q == IDLE) & go & ~misalign;
    assign align_err = (state_q == IDLE) & go & misalign;

    // Timeout fires on the TIMEOUT-th BUSY cycle; a coincident m_done takes priority.
    generate
        if (TIMEOUT != 0) begin : g_timeout
            assign timeout = (state_q == BUSY) & ~m_done & (cnt_q == CW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    assign err_d = err_q | m_err | err_in | timeout | align_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            m_rd_q    <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= err_d;
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        m_addr_q  <= addr;
                        m_wdata_q <= wdata;
                        m_rd_q    <= mem_read;
                        m_wr_q    <= mem_write & ~mem_read;
                        cnt_q     <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (m_done) begin
                        if (m_rd_q) rdata_q <= m_rdata;
                        m_rd_q  <= 1'b0;
                        m_wr_q  <= 1'b0;
                        state_q <= DONE;
                    end else if (timeout) begin
                        m_rd_q  <= 1'b0;
                        m_wr_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // Forced bubble: the request still held here is treated as already served.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_stall = issue | (state_q == BUSY);
    assign halt_out  = halt_in & ~mem_stall;
    assign m_dump    = halt_out;
    assign m_rd      = m_rd_q;
    assign m_wr      = m_wr_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: random pipeline accesses against a latency-randomised memory model,
// plus directed blocking, halt, timeout, error and reset scenarios.
module tb_mem_stage_ctrl;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 4;
    localparam int CW = 3;

    logic          clk, rst;
    logic          mem_read, mem_write, halt_in, err_in, global_err, stall_up;
    logic [AW-1:0] addr, m_addr;
    logic [DW-1:0] wdata, m_wdata, m_rdata, rdata;
    logic          m_rd, m_wr, m_done, m_err, m_dump, mem_stall, halt_out, err;

    mem_stage_ctrl #(.DW(DW), .AW(AW), .TIMEOUT(TO), .CW(CW)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
        .halt_in(halt_in), .err_in(err_in), .global_err(global_err), .stall_up(stall_up),
        .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_done(m_done), .m_err(m_err), .m_dump(m_dump), .rdata(rdata), .mem_stall(mem_stall),
        .halt_out(halt_out), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit            rd;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd_exp;
        bit            hang;
    } acc_t;

    acc_t          exp_q[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            force_lat = 0;
    int            last_lat = 0;
    bit            hang = 0;
    bit            noise = 0;
    logic [DW-1:0] model_rdata = '0;

    function automatic logic [DW-1:0] mem_val(logic [AW-1:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    endtask

    // Memory model: answers the L-th BUSY cycle, random L in 1..TO unless forced; hang never answers.
    initial begin
        int busy_cnt, cur_lat;
        busy_cnt = 0; cur_lat = 1;
        m_done = 1'b0; m_rdata = '0;
        forever begin
            @(negedge clk); #3;
            m_done = 1'b0;
            if (rst || !(m_rd || m_wr)) begin
                busy_cnt = 0;
                if (noise && !rst && $urandom_range(0, 3) == 0) begin
                    m_done  = 1'b1;
                    m_rdata = DW'($urandom);
                end
            end else begin
                busy_cnt++;
                if (busy_cnt == 1) cur_lat = (force_lat != 0) ? force_lat : $urandom_range(1, TO);
                if (!hang && busy_cnt == cur_lat) begin
                    m_done   = 1'b1;
                    last_lat = cur_lat;
                    m_rdata  = m_rd ? mem_val(m_addr) : DW'($urandom);
                end
            end
        end
    end

    // Monitor: pops an expectation when a strobe rises, checks the result when it falls.
    initial begin
        bit   prev, have, s;
        acc_t cur;
        prev = 0; have = 0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                prev = 0; have = 0;
            end else begin
                s = m_rd | m_wr;
                if (s && !prev) begin
                    if (exp_q.size() == 0) chk("unexpected_access", 1, 0);
                    else begin
                        cur = exp_q.pop_front();
                        have = 1;
                        chk("acc_rd", m_rd, cur.rd);
                        chk("acc_wr", m_wr, cur.wr);
                        chk("acc_addr", m_addr, cur.a);
                        if (cur.wr) chk("acc_wdata", m_wdata, cur.wd);
                    end
                end else if (!s && prev && have) begin
                    chk("rdata", rdata, cur.rd_exp);
                    chk("err_after", err, cur.hang);
                    have = 0;
                end
                prev = s;
            end
        end
    end

    task automatic do_access(bit rd, bit wr, logic [AW-1:0] a, logic [DW-1:0] wd, int up, bit hng, bit hlt);
        acc_t e;
        int   n, exp_n;
        e.rd = rd; e.wr = wr & ~rd; e.a = a; e.wd = wd; e.hang = hng;
        e.rd_exp = (rd && !hng) ? mem_val(a) : model_rdata;
        if (rd && !hng) model_rdata = e.rd_exp;
        @(negedge clk);
        hang = hng; mem_read = rd; mem_write = wr; addr = a; wdata = wd; halt_in = hlt;
        stall_up = (up > 0);
        for (int i = 0; i < up; i++) begin
            #1;
            chk("upstall_stall", mem_stall, 0);
            chk("upstall_strobe", m_rd | m_wr, 0);
            @(negedge clk);
        end
        stall_up = 1'b0;
        exp_q.push_back(e);
        n = 0;
        forever begin
            #1;
            if (!mem_stall) break;
            if (hlt) chk("halt_busy", halt_out, 0);
            n++;
            if (n > 40) begin
                chk("stall_bound", n, 0);
                break;
            end
            @(negedge clk);
        end
        exp_n = hng ? TO + 1 : last_lat + 1;
        chk("stall_cycles", n, exp_n);
        if (hlt) begin
            chk("halt_done", halt_out, 1);
            chk("dump_done", m_dump, 1);
        end
        halt_in = 1'b0;
    endtask

    task automatic blocked(string nm, bit rd, bit wr, bit ge, int cyc, bit exp_err);
        @(negedge clk);
        mem_read = rd; mem_write = wr; global_err = ge; addr = 16'h0020; wdata = 16'h1234;
        for (int i = 0; i < cyc; i++) begin
            #1;
            chk({nm, "_stall"}, mem_stall, 0);
            chk({nm, "_strobe"}, m_rd | m_wr, 0);
            chk({nm, "_err"}, err, exp_err);
            @(negedge clk);
        end
        mem_read = 1'b0; mem_write = 1'b0; global_err = 1'b0;
    endtask

    task automatic idle(int cyc);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        for (int i = 0; i < cyc; i++) begin
            #1;
            chk("idle_stall", mem_stall, 0);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; err_in = 1'b0; m_err = 1'b0;
        global_err = 1'b0; stall_up = 1'b0; halt_in = 1'b0;
        @(negedge clk); #1;
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_strobe", m_rd | m_wr, 0);
        rst = 1'b0; hang = 1'b0; model_rdata = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; mem_read = 0; mem_write = 0; addr = '0; wdata = '0; halt_in = 0;
        err_in = 0; global_err = 0; stall_up = 0; m_err = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_m_rd", m_rd, 0);
        chk("reset_m_wr", m_wr, 0);
        chk("reset_m_addr", m_addr, 0);
        chk("reset_m_wdata", m_wdata, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_stall", mem_stall, 0);
        chk("reset_halt", halt_out, 0);
        chk("reset_dump", m_dump, 0);
        chk("reset_err", err, 0);
        rst = 1'b0;

        // Random traffic with stray m_done pulses while idle.
        noise = 1;
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 2);
            do_access(k != 0, k != 1, AW'($urandom) & 16'hFFFE, DW'($urandom),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 0,
                      $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        noise = 0;

        force_lat = 3;
        do_access(1, 0, 16'h0010, 16'h0000, 0, 0, 0);
        do_access(0, 1, 16'h0020, 16'h1234, 2, 0, 0);
        do_access(0, 1, 16'h0030, 16'h5678, 0, 0, 1);
        force_lat = TO;
        do_access(1, 0, 16'h0040, 16'h0000, 0, 0, 0);
        force_lat = 0;
        blocked("gerr", 0, 1, 1, 3, 0);

`ifdef MEM_ALIGN_CHK_EN
        @(negedge clk);
        mem_read = 1'b1; addr = 16'h0011;
        #1 chk("align_stall", mem_stall, 0);
        @(negedge clk); #1;
        chk("align_err", err, 1);
        chk("align_no_rd", m_rd, 0);
        blocked("align_blk", 1, 0, 0, 2, 1);
        do_reset();
`else
        do_access(1, 0, 16'h0011, 16'h0000, 0, 0, 0);
`endif

        // Reset while an access is outstanding.
        do_access(1, 0, 16'h0050, 16'h0000, 0, 0, 0);
        begin
            acc_t e;
            e.rd = 1; e.wr = 0; e.a = 16'h0042; e.wd = '0; e.rd_exp = '0; e.hang = 1;
            @(negedge clk);
            hang = 1; mem_read = 1'b1; addr = 16'h0042;
            exp_q.push_back(e);
            repeat (2) @(negedge clk);
            #1 chk("midrst_pre_rd", m_rd, 1);
            @(negedge clk);
            rst = 1'b1; mem_read = 1'b0;
            @(negedge clk); #1;
            chk("midrst_rd", m_rd, 0);
            chk("midrst_rdata", rdata, 0);
            chk("midrst_stall", mem_stall, 0);
            rst = 1'b0; hang = 1'b0; model_rdata = '0;
        end

        do_access(1, 0, 16'h0060, 16'h0000, 0, 1, 0);
        blocked("to_blk", 1, 0, 0, 3, 1);
        do_reset();

        @(negedge clk); err_in = 1'b1;
        @(negedge clk); err_in = 1'b0;
        #1 chk("err_in_set", err, 1);
        blocked("errin_blk", 1, 1, 0, 2, 1);
        do_reset();

        @(negedge clk); m_err = 1'b1;
        @(negedge clk); m_err = 1'b0;
        #1 chk("m_err_set", err, 1);
        blocked("merr_blk", 0, 1, 0, 2, 1);
        do_reset();

        do_access(1, 0, 16'h0070, 16'h0000, 0, 0, 0);
        idle(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
